// File: rtl/axis_pkg.sv
// Shared types and defaults for the AXI-Stream packet receiver.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVF  = 2'd2
  } rx_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W      = 8;

  // Next beat count; restart means this beat opens a new packet.
  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] len,
                                               input logic             restart);
    logic [LEN_W-1:0] base;
    base    = restart ? {LEN_W{1'b0}} : len;
    len_inc = base + {{(LEN_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on o_rd_data while not empty.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_en,
  output logic [W-1:0]             o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = o_empty ? {W{1'b0}} : r_mem[r_rd_ptr];

  // A full FIFO refuses writes even when a pop happens in the same cycle.
  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_s_rx.sv
// AXI-Stream slave: frames beats into packets, buffers them in a FWFT FIFO and
// reports length, modulo sum and overlength error per completed packet.
module axis_s_rx
  import axis_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_areset,
  input  logic                     s_axis_tvalid,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_last,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_done,
  output logic [7:0]               pkt_len,
  output logic [DATA_W-1:0]        pkt_sum,
  output logic                     pkt_err
);

  rx_state_t         r_state;
  rx_state_t         w_next;
  logic              w_ready;
  logic              w_acc;
  logic              w_store;
  logic              w_restart;
  logic              w_hit_max;
  logic              w_tlast_eff;
  logic              w_complete;
  logic [LEN_W-1:0]  w_len_new;
  logic [DATA_W-1:0] w_sum_new;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_sum;
  logic              r_pkt_done;
  logic [7:0]        r_pkt_len;
  logic [DATA_W-1:0] r_pkt_sum;
  logic              r_pkt_err;
  logic [DATA_W:0]   w_rd_data;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RECV: begin
        if (w_acc) begin
          if (s_axis_tlast) begin
            w_next = IDLE;
          end else if (w_hit_max) begin
            w_next = OVF;
          end else begin
            w_next = RECV;
          end
        end else begin
          w_next = r_state;
        end
      end
      OVF: begin
        if (w_acc && s_axis_tlast) begin
          w_next = IDLE;
        end else begin
          w_next = OVF;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // While discarding an overlength tail the master is never stalled.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE, RECV: w_ready = !full;
      OVF:        w_ready = 1'b1;
      default:    w_ready = 1'b0;
    endcase
  end

  assign s_axis_tready = w_ready && !s_axis_areset;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_store       = w_acc && (r_state != OVF);
  assign w_complete    = w_acc && s_axis_tlast;
  assign w_restart     = (r_state == IDLE);
  assign w_len_new     = len_inc(r_len, w_restart);
  assign w_sum_new     = (w_restart ? {DATA_W{1'b0}} : r_sum) + s_axis_tdata;
  assign w_hit_max     = (w_len_new == LEN_W'(MAX_LEN));
  assign w_tlast_eff   = s_axis_tlast || w_hit_max;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_len      <= {LEN_W{1'b0}};
      r_sum      <= {DATA_W{1'b0}};
      r_pkt_done <= 1'b0;
      r_pkt_len  <= 8'd0;
      r_pkt_sum  <= {DATA_W{1'b0}};
      r_pkt_err  <= 1'b0;
    end else begin
      r_pkt_done <= w_complete;
      if (w_store) begin
        r_len <= w_len_new;
        r_sum <= w_sum_new;
      end
      // An overlength packet reports the truncated totals frozen at entry to OVF.
      if (w_complete) begin
        if (r_state == OVF) begin
          r_pkt_len <= r_len;
          r_pkt_sum <= r_sum;
          r_pkt_err <= 1'b1;
        end else begin
          r_pkt_len <= w_len_new;
          r_pkt_sum <= w_sum_new;
          r_pkt_err <= 1'b0;
        end
      end
    end
  end

  axis_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (s_axis_aclk),
    .i_rst     (s_axis_areset),
    .i_wr_en   (w_store),
    .i_wr_data ({w_tlast_eff, s_axis_tdata}),
    .i_rd_en   (rd_en),
    .o_rd_data (w_rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count)
  );

  assign dout      = w_rd_data[DATA_W-1:0];
  assign dout_last = w_rd_data[DATA_W];
  assign pkt_done  = r_pkt_done;
  assign pkt_len   = r_pkt_len;
  assign pkt_sum   = r_pkt_sum;
  assign pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_axis_s_rx.sv
// Directed bench for axis_s_rx: vector table plus hand sequences for
// backpressure, overlength truncation and mid-packet reset.
module tb_axis_s_rx;

  logic       clk;
  logic       areset;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tlast;
  logic       tready;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_last;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic [7:0] pkt_sum;
  logic       pkt_err;

  int total = 0;
  int bad   = 0;
  int nacc  = 0;
  int npop  = 0;
  int ndone = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       rd;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic       dl;
    logic       done;
    logic [7:0] len;
    logic [7:0] sum;
  } vec_t;

  vec_t vt[17];

  axis_s_rx #(.DATA_W(8), .DEPTH(8), .MAX_LEN(16)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (areset),
    .s_axis_tvalid (tvalid),
    .s_axis_tdata  (tdata),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .rd_en         (rd_en),
    .dout          (dout),
    .dout_last     (dout_last),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .pkt_done      (pkt_done),
    .pkt_len       (pkt_len),
    .pkt_sum       (pkt_sum),
    .pkt_err       (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock: score any pop against the expected queue, count accepts and done pulses.
  task automatic tick();
    logic [8:0] e;
    #2;
    if (rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", {23'd0, dout_last, dout}, 32'h1ff);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", dout, e[7:0]);
        chk("pop_last", dout_last, e[8]);
      end
      npop++;
    end
    if (tvalid && tready) nacc++;
    @(posedge clk);
    #1;
    if (pkt_done) ndone++;
  endtask

  initial begin
    logic ok;
    int   budget;

    vt[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 4'd1, 8'h10, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[1]  = '{1'b1, 8'h20, 1'b0, 1'b0, 4'd2, 8'h10, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[2]  = '{1'b1, 8'h30, 1'b0, 1'b0, 4'd3, 8'h10, 1'b0, 1'b0, 8'd0, 8'h00};
    vt[3]  = '{1'b1, 8'h40, 1'b1, 1'b0, 4'd4, 8'h10, 1'b0, 1'b1, 8'd4, 8'hA0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 8'h20, 1'b0, 1'b0, 8'd4, 8'hA0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 8'h30, 1'b0, 1'b0, 8'd4, 8'hA0};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 8'h40, 1'b1, 1'b0, 8'd4, 8'hA0};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'd4, 8'hA0};
    vt[8]  = '{1'b1, 8'h01, 1'b0, 1'b0, 4'd1, 8'h01, 1'b0, 1'b0, 8'd4, 8'hA0};
    vt[9]  = '{1'b1, 8'h02, 1'b0, 1'b0, 4'd2, 8'h01, 1'b0, 1'b0, 8'd4, 8'hA0};
    vt[10] = '{1'b1, 8'h03, 1'b0, 1'b0, 4'd3, 8'h01, 1'b0, 1'b0, 8'd4, 8'hA0};
    vt[11] = '{1'b1, 8'h04, 1'b1, 1'b1, 4'd3, 8'h02, 1'b0, 1'b1, 8'd4, 8'h0A};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 8'h03, 1'b0, 1'b0, 8'd4, 8'h0A};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 8'h04, 1'b1, 1'b0, 8'd4, 8'h0A};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'd4, 8'h0A};
    vt[15] = '{1'b1, 8'hFF, 1'b1, 1'b0, 4'd1, 8'hFF, 1'b1, 1'b1, 8'd1, 8'hFF};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'd1, 8'hFF};

    areset = 1'b1;
    tvalid = 1'b0;
    tdata  = 8'h00;
    tlast  = 1'b0;
    rd_en  = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", {dout_last, dout}, 0);
    chk("rst_status", {pkt_done, pkt_err, pkt_len, pkt_sum}, 0);
    areset = 1'b0;
    #1;
    chk("rel_tready", tready, 1);

    // Table: 4-beat packet + drain, simultaneous write/read at count 3, single-beat packet.
    for (int i = 0; i < 17; i++) begin
      tvalid = vt[i].v;
      tdata  = vt[i].d;
      tlast  = vt[i].l;
      rd_en  = vt[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, vt[i].cnt == 4'd0);
      chk($sformatf("v%0d_dout", i), dout, vt[i].dout);
      chk($sformatf("v%0d_dlast", i), dout_last, vt[i].dl);
      chk($sformatf("v%0d_done", i), pkt_done, vt[i].done);
      chk($sformatf("v%0d_len", i), pkt_len, vt[i].len);
      chk($sformatf("v%0d_sum", i), pkt_sum, vt[i].sum);
      chk($sformatf("v%0d_err", i), pkt_err, 0);
      chk($sformatf("v%0d_tready", i), tready, 1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    rd_en  = 1'b0;

    // Backpressure: 10-beat packet into an 8-deep FIFO.
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9) ? 1'b1 : 1'b0, 8'(8'h50 + i)});
    nacc = 0; npop = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tvalid = 1'b1;
      tdata  = 8'(8'h50 + i);
      tlast  = 1'b0;
      #1;
      chk("bp_tready_fill", tready, 1);
      tick();
    end
    chk("bp_full", full, 1);
    chk("bp_tready_low", tready, 0);
    chk("bp_count8", count, 8);
    tdata = 8'h58;
    tick();
    chk("bp_stall_count", count, 8);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("bp_pop_count", count, 7);
    chk("bp_pop_tready", tready, 1);
    tick();
    chk("bp_refill_count", count, 8);
    chk("bp_refill_tready", tready, 0);
    tdata = 8'h59;
    tlast = 1'b1;
    tick();
    tick();
    chk("bp_one_more_count", count, 8);
    chk("bp_one_more_acc", nacc, 9);
    rd_en  = 1'b1;
    budget = 0;
    while (!(tvalid == 1'b0 && empty && ndone >= 1) && budget < 40) begin
      ok = tvalid && tready;
      tick();
      if (ok) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
      end
      budget++;
    end
    chk("bp_drain_timeout", budget < 40, 1);
    chk("bp_acc", nacc, 10);
    chk("bp_pops", npop, 10);
    chk("bp_done_cnt", ndone, 1);
    chk("bp_len", pkt_len, 10);
    chk("bp_sum", pkt_sum, 8'h4D);
    chk("bp_err", pkt_err, 0);

    // Overlength: 20 beats 1..20, only the first 16 stored, beat 16 marked last.
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back({(i == 16) ? 1'b1 : 1'b0, 8'(i)});
    nacc = 0; npop = 0; ndone = 0;
    rd_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tvalid = 1'b1;
      tdata  = 8'(i);
      tlast  = (i == 20);
      #1;
      if (i > 16) chk($sformatf("ovf_tready_%0d", i), tready, 1);
      budget = 0;
      ok     = 1'b0;
      while (!ok && budget < 10) begin
        ok = tready;
        tick();
        budget++;
      end
      chk("ovf_accept_timeout", ok, 1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    budget = 0;
    while (!empty && budget < 10) begin
      tick();
      budget++;
    end
    chk("ovf_acc", nacc, 20);
    chk("ovf_pops", npop, 16);
    chk("ovf_q_left", exp_q.size(), 0);
    chk("ovf_count", count, 0);
    chk("ovf_done_cnt", ndone, 1);
    chk("ovf_len", pkt_len, 16);
    chk("ovf_sum", pkt_sum, 8'h88);
    chk("ovf_err", pkt_err, 1);

    // Reset in the middle of a packet, then a fresh 3-beat packet.
    rd_en = 1'b0;
    exp_q.delete();
    ndone = 0;
    for (int i = 0; i < 2; i++) begin
      tvalid = 1'b1;
      tdata  = (i == 0) ? 8'h11 : 8'h22;
      tlast  = 1'b0;
      tick();
    end
    tvalid = 1'b0;
    chk("mr_count2", count, 2);
    areset = 1'b1;
    #1;
    chk("mr_tready", tready, 0);
    chk("mr_empty", empty, 1);
    chk("mr_len_clr", pkt_len, 0);
    tick();
    tick();
    areset = 1'b0;
    #1;
    chk("mr_no_done", ndone, 0);
    chk("mr_tready_rel", tready, 1);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, 8'(i)});
      tvalid = 1'b1;
      tdata  = 8'(i);
      tlast  = (i == 3);
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("mr_done_cnt", ndone, 1);
    chk("mr_len", pkt_len, 3);
    chk("mr_sum", pkt_sum, 8'h06);
    chk("mr_err", pkt_err, 0);
    npop   = 0;
    rd_en  = 1'b1;
    budget = 0;
    while (!empty && budget < 10) begin
      tick();
      budget++;
    end
    rd_en = 1'b0;
    chk("mr_pops", npop, 3);
    chk("mr_q_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_s_rx.md
# axis_s_rx

AXI-Stream slave receiver for the byte-stream fabric: it accepts beats from an AXI-Stream master (tvalid/tready/tdata/tlast), frames them into packets and buffers them in a small FIFO. A local consumer drains the FIFO through a first-word-fall-through read port. For every completed packet it reports the length, a modulo byte sum and an overlength error.

## Interface
- DATA_W, 8, tdata width in bits.
- DEPTH, 8, FIFO depth in entries; power of 2, at least 2.
- MAX_LEN, 16, maximum number of beats stored per packet; range 1..255.
- s_axis_aclk  in  1  single clock; all logic is on its rising edge.
- s_axis_areset  in  1  reset, asynchronous and active-high.
- s_axis_tvalid  in  1  master beat valid.
- s_axis_tdata  in  DATA_W  beat data.
- s_axis_tlast  in  1  final beat of the packet.
- s_axis_tready  out  1  slave ready.
- rd_en  in  1  pops the FIFO head; ignored when empty.
- dout  out  DATA_W  FIFO head data; 0 when empty.
- dout_last  out  1  FIFO head is the packet's final stored beat.
- empty / full  out  1 each  FIFO status.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- pkt_done  out  1  one-cycle pulse per completed packet.
- pkt_len  out  8  number of stored beats in the last completed packet.
- pkt_sum  out  DATA_W  sum of stored beats, mod 2^DATA_W.
- pkt_err  out  1  last completed packet exceeded MAX_LEN.

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready. Data and tlast are sampled in that cycle.
- FSM states:
  - IDLE: no beat of the current packet has been accepted yet.
  - RECV: at least one beat accepted, tlast not yet seen.
  - OVF: discarding the tail of an overlength packet.
- IDLE→RECV: a beat is accepted with tlast=0.
- IDLE stays IDLE: a beat is accepted with tlast=1 (single-beat packet).
- RECV→IDLE: an accepted beat has tlast=1.
- RECV→OVF: the MAX_LEN-th beat is accepted with tlast=0. That beat is stored with dout_last forced to 1 (truncation).
- OVF→IDLE: an accepted beat has tlast=1.
- tready:
  - IDLE/RECV: tready = !full (combinational).
  - OVF: tready = 1. Beats are consumed and dropped; nothing is written to the FIFO and the length/sum counters do not change.
- The FIFO entry is {tlast_eff, tdata}. Write and read in the same cycle leave count unchanged.
- When full, no write occurs even if rd_en is high that cycle: tready is low, with no read-through.
- A running length (8-bit) and sum (DATA_W, wrapping) accumulate over stored beats. Both restart from the first beat of each packet.
- On packet completion, the cycle after tlast is accepted:
  - pkt_done=1 for exactly one cycle.
  - pkt_len, pkt_sum and pkt_err are loaded. pkt_err=1 only for a packet that went through OVF.
  - These values are held until the next pkt_done.
- A packet of exactly MAX_LEN beats whose tlast falls on the MAX_LEN-th beat completes normally: IDLE/RECV→IDLE, pkt_err=0.
- When tvalid=0, state and counters hold. tdata/tlast are don't-care while tvalid=0.

## Timing
- Reset (asynchronous assert, synchronous-to-edge deassert use):
  - FSM=IDLE, FIFO flushed.
  - count=0, empty=1, full=0, dout=0, dout_last=0.
  - pkt_done=0, pkt_len=0, pkt_sum=0, pkt_err=0.
  - s_axis_tready=0 while reset is asserted; tready=1 in the first cycle after release.
- Reset mid-packet: the partial packet is discarded, no pkt_done is produced, and the next accepted beat starts a new packet.
- Write latency: a beat accepted at edge N is visible on dout (if the FIFO was empty) after edge N, so empty=0 in cycle N+1.
- Pop: rd_en high at edge N advances the head after edge N.
- pkt_done is registered: tlast accepted at edge N gives pkt_done high between edges N and N+1.
- full and empty are derived from registered pointers and count; no combinational path from s_axis_tvalid to tready.

## Structure
- Package axis_pkg:
  - typedef enum rx_state_t {IDLE, RECV, OVF}.
  - default width constants for DATA_W and the length counter.
- Sub-module axis_fifo: synchronous FWFT FIFO of width DATA_W+1 and depth DEPTH, with count/full/empty outputs and asynchronous active-high reset. It is instantiated once.
- FSM, counters and packet-status registers are in axis_s_rx.

## Test plan
- Reset:
  - Hold s_axis_areset=1 for 3 cycles → tready=0, empty=1, count=0, all status outputs 0.
  - Release → tready=1 on the next cycle.
- Normal packet: 4-beat packet 0x10,0x20,0x30,0x40 (tlast on 4th), rd_en=0 →
  - count=4 and one pkt_done with len=4, sum=0xA0, err=0.
  - Draining yields the same order, with dout_last=1 only on 0x40.
- Backpressure: DEPTH=8, 10-beat packet with rd_en=0 →
  - tready=0 after the 8th acceptance, full=1.
  - A single rd_en pulse lets exactly one more beat in.
  - Draining completes the packet with len=10.
- Overlength: MAX_LEN=16, 20-beat packet of values 1..20 with rd_en=1 →
  - 16 beats are output, and beat 16 has dout_last=1.
  - Beats 17–20 are accepted with tready=1 but not stored.
  - pkt_done with len=16, sum=136 (0x88), err=1.
- Simultaneous access: count=3, write and rd_en in the same cycle → count stays 3 and data order is preserved.
- Single-beat and mid-packet reset:
  - Single-beat tlast packet 0xFF → len=1, sum=0xFF.
  - Reset after 2 beats of a packet → no pkt_done, empty=1.
  - A following 3-beat packet reports len=3.
